dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_arb_rr.sv | 66 ++++++
 rtl/dmem_arbiter.sv | 83 ++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared widths and priority-pointer encoding for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned DMEM_AW = 32;
    localparam int unsigned DMEM_DW = 32;
    localparam int unsigned DMEM_BE = 4;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_e;

endpackage

// File: rtl/dmem_arb_rr.sv
// Grant decision for the two data-memory masters. Define DMEM_ARB_RR_EN for
// round-robin with MAX_BURST limiting; otherwise m0 has fixed priority.
module dmem_arb_rr
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef DMEM_ARB_RR_EN
    pri_e       ptr_q;
    logic [3:0] cnt_q;
    logic       owner_q;  // last master granted, used to spot owner changes

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt0 = (ptr_q == PRI0);
                gnt1 = (ptr_q == PRI1);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= PRI0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
        end else if (req0 && req1) begin
            owner_q <= (ptr_q == PRI1);
            if (cnt_q == 4'(MAX_BURST - 1)) begin
                ptr_q <= (ptr_q == PRI0) ? PRI1 : PRI0;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end else if (req0 || req1) begin
            owner_q <= req1;
            if (owner_q != req1) begin
                cnt_q <= '0;
            end
        end else begin
            cnt_q <= '0;
        end
    end
`else
    localparam int unsigned unused_max_burst = MAX_BURST;
    logic unused_clk;
    assign unused_clk = clk;

    assign gnt0 = !reset && req0;
    assign gnt1 = !reset && req1 && !req0;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: grant, address/data mux and 1-cycle read return.
// Arbitration policy selected by DMEM_ARB_RR_EN (see dmem_arb_rr).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m0_req,
    input  logic [DMEM_AW-1:0] m0_addr,
    input  logic [DMEM_DW-1:0] m0_wdata,
    input  logic [DMEM_BE-1:0] m0_we,
    output logic               m0_gnt,
    output logic               m0_rvalid,
    output logic [DMEM_DW-1:0] m0_rdata,
    input  logic               m1_req,
    input  logic [DMEM_AW-1:0] m1_addr,
    input  logic [DMEM_DW-1:0] m1_wdata,
    input  logic [DMEM_BE-1:0] m1_we,
    output logic               m1_gnt,
    output logic               m1_rvalid,
    output logic [DMEM_DW-1:0] m1_rdata,
    output logic [DMEM_AW-1:0] daddr,
    output logic [DMEM_DW-1:0] dwdata,
    output logic [DMEM_BE-1:0] dwe,
    input  logic [DMEM_DW-1:0] drdata
);

    logic               m0_rvalid_q, m1_rvalid_q;
    logic [DMEM_DW-1:0] m0_rdata_q, m1_rdata_q;

    dmem_arb_rr #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clk  (clk),
        .reset(reset),
        .req0 (m0_req),
        .req1 (m1_req),
        .gnt0 (m0_gnt),
        .gnt1 (m1_gnt)
    );

    always_comb begin
        daddr  = '0;
        dwdata = '0;
        dwe    = '0;
        if (m0_gnt) begin
            daddr  = m0_addr;
            dwdata = m0_wdata;
            dwe    = m0_we;
        end else if (m1_gnt) begin
            daddr  = m1_addr;
            dwdata = m1_wdata;
            dwe    = m1_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            m0_rvalid_q <= m0_gnt && (m0_we == '0);
            m1_rvalid_q <= m1_gnt && (m1_we == '0);
            if (m0_gnt && (m0_we == '0)) begin
                m0_rdata_q <= drdata;
            end
            if (m1_gnt && (m1_we == '0)) begin
                m1_rdata_q <= drdata;
            end
        end
    end

    // A response already registered when reset rises must not be seen.
    assign m0_rvalid = m0_rvalid_q && !reset;
    assign m1_rvalid = m1_rvalid_q && !reset;
    assign m0_rdata  = reset ? '0 : m0_rdata_q;
    assign m1_rdata  = reset ? '0 : m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-enabled memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_we, m1_we;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dwe;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .MAX_BURST(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_we    (m0_we),
        .m0_gnt   (m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_we    (m1_we),
        .m1_gnt   (m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata (m1_rdata),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .dwe      (dwe),
        .drdata   (drdata)
    );

    assign drdata = mem[daddr[7:2]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h11223344;
        end else begin
            for (int b = 0; b < 4; b++)
                if (dwe[b]) mem[daddr[7:2]][8*b +: 8] <= dwdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0;
        m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_we = 0;
    endtask

    task automatic drv0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        m0_req = 1; m0_addr = a; m0_wdata = d; m0_we = we;
    endtask

    task automatic drv1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        m1_req = 1; m1_addr = a; m1_wdata = d; m1_we = we;
    endtask

    initial begin
        logic exp0;
        idle();
        reset = 1;
        drv0(32'h40, 32'hFFFFFFFF, 4'hF);
        #1;
        chk("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
        chk("rst_dwe", {28'b0, dwe}, 32'd0);
        tick(); tick();
        chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);

        // m0 write then read-back
        reset = 0;
        drv0(32'h40, 32'hDEADBEEF, 4'hF);
        #1;
        chk("wr_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        chk("wr_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        chk("wr_daddr", daddr, 32'h40);
        chk("wr_dwdata", dwdata, 32'hDEADBEEF);
        chk("wr_dwe", {28'b0, dwe}, 32'hF);
        tick();
        drv0(32'h40, 32'h0, 4'h0);
        #1;
        chk("rd_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        chk("wr_no_rvalid", {31'b0, m0_rvalid}, 32'd0);
        tick();
        idle();
        #1;
        chk("rd_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("idle_daddr", daddr, 32'd0);
        chk("idle_dwdata", dwdata, 32'd0);
        chk("idle_dwe", {28'b0, dwe}, 32'd0);
        tick();
        chk("rvalid_pulse_end", {31'b0, m0_rvalid}, 32'd0);
        chk("rdata_hold", m0_rdata, 32'hDEADBEEF);

        // m1 byte write over preloaded word
        drv1(32'h10, 32'h000000AB, 4'b0001);
        #1;
        chk("bw_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        chk("bw_dwe", {28'b0, dwe}, 32'h1);
        tick();
        drv1(32'h10, 32'h0, 4'h0);
        tick();
        idle();
        #1;
        chk("bw_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
        chk("bw_m1_rdata", m1_rdata, 32'h112233AB);
        chk("bw_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
        tick();

        // m1 alone, alternating read/write, no bubbles
        drv1(32'h40, 32'h0, 4'h0);
        #1;
        chk("alt0_gnt", {31'b0, m1_gnt}, 32'd1);
        chk("alt0_rvalid", {31'b0, m1_rvalid}, 32'd0);
        tick();
        drv1(32'h44, 32'h00000055, 4'hF);
        #1;
        chk("alt1_gnt", {31'b0, m1_gnt}, 32'd1);
        chk("alt1_rvalid", {31'b0, m1_rvalid}, 32'd1);
        chk("alt1_rdata", m1_rdata, 32'hDEADBEEF);
        tick();
        drv1(32'h44, 32'h0, 4'h0);
        #1;
        chk("alt2_gnt", {31'b0, m1_gnt}, 32'd1);
        chk("alt2_rvalid", {31'b0, m1_rvalid}, 32'd0);
        tick();
        drv1(32'h48, 32'h00000066, 4'hF);
        #1;
        chk("alt3_gnt", {31'b0, m1_gnt}, 32'd1);
        chk("alt3_rvalid", {31'b0, m1_rvalid}, 32'd1);
        chk("alt3_rdata", m1_rdata, 32'h00000055);
        tick();
        idle();
        #1;
        chk("alt4_rvalid", {31'b0, m1_rvalid}, 32'd0);
        tick();

        // Same-address contention: m0 write wins, m1 read follows and sees new data
        drv0(32'h20, 32'h12345678, 4'hF);
        drv1(32'h20, 32'h0, 4'h0);
        #1;
        chk("same_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        chk("same_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        tick();
        m0_req = 0; m0_we = 0;
        #1;
        chk("same_m1_gnt2", {31'b0, m1_gnt}, 32'd1);
        tick();
        idle();
        #1;
        chk("same_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
        chk("same_m1_rdata", m1_rdata, 32'h12345678);
        tick();

        // Continuous contention from reset
        reset = 1;
        tick();
        reset = 0;
        drv0(32'h10, 32'h0, 4'h0);
        drv1(32'h10, 32'h0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            #1;
`ifdef DMEM_ARB_RR_EN
            exp0 = ((i / 4) % 2) == 0;
`else
            exp0 = 1'b1;
`endif
            chk($sformatf("cont%0d_m0_gnt", i), {31'b0, m0_gnt}, {31'b0, exp0});
            chk($sformatf("cont%0d_m1_gnt", i), {31'b0, m1_gnt}, {31'b0, ~exp0});
            tick();
        end
        idle();
        tick();
        reset = 1;
        tick();
        reset = 0;
        tick();

        // Reset right after an m1 read grant drops the response
        drv1(32'h10, 32'h0, 4'h0);
        #1;
        chk("rst_rd_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        tick();
        idle();
        reset = 1;
        #1;
        chk("rst_rd_rvalid_a", {31'b0, m1_rvalid}, 32'd0);
        chk("rst_rd_rdata_a", m1_rdata, 32'd0);
        tick();
        reset = 0;
        #1;
        chk("rst_rd_rvalid_b", {31'b0, m1_rvalid}, 32'd0);
        chk("rst_rd_rdata_b", m1_rdata, 32'd0);
        tick();
        chk("rst_rd_rvalid_c", {31'b0, m1_rvalid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
